// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between producer engines, the burst arbiter and one sync FIFO.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 15,
  parameter int unsigned DW   = 18,
  parameter int unsigned BLW  = 8
);
  logic [NREQ-1:0]     req;
  logic [NREQ*BLW-1:0] req_len;
  logic [NREQ-1:0]     req_vld;
  logic [NREQ*DW-1:0]  req_din;
  logic [NREQ-1:0]     gnt;
  logic [AW:0]         room_avail;
  logic                fifo_wen;
  logic [DW-1:0]       fifo_din;
  logic                busy;
  logic [2:0]          cur_id;
  logic                err;

  modport master (
    input  req, req_len, req_vld, req_din, room_avail,
    output gnt, fifo_wen, fifo_din, busy, cur_id, err
  );

  modport slave (
    output req, req_len, req_vld, req_din, room_avail,
    input  gnt, fifo_wen, fifo_din, busy, cur_id, err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for one FIFO write port; a burst is granted only if it fits.
// Optional idle-word watchdog enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AW     = 15,
  parameter int unsigned DW     = 18,
  parameter int unsigned BLW    = 8,
  parameter int unsigned TO_CYC = 64
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned IW = 3;
  localparam int unsigned CW = ((AW + 1) > BLW) ? (AW + 1) : BLW;

  typedef enum logic [1:0] {IDLE, ARB, BURST, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_q, gnt_nxt;
  logic            fifo_wen_q, fifo_wen_nxt;
  logic [DW-1:0]   fifo_din_q, fifo_din_nxt, cur_din;
  logic            busy_q;
  logic [IW-1:0]   cur_id_q, cur_id_nxt, rr_ptr, rr_ptr_nxt, cand, idx;
  logic [BLW-1:0]  cnt, cnt_nxt, cand_len, burst_len;
  logic            drain, drain_nxt, err_q, err_nxt;
  logic [7:0]      req8;
  logic            any_req, found, fits, accept, last_word, to_hit;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    req8  = 8'(bus.req);
    cand  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(rr_ptr) + i) % NREQ);
      if (!found && req8[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  always_comb begin
    cand_len = '0;
    cur_din  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (cand == IW'(i))     cand_len = bus.req_len[i*BLW +: BLW];
      if (cur_id_q == IW'(i)) cur_din  = bus.req_din[i*DW +: DW];
    end
  end

  assign any_req   = |bus.req;
  assign burst_len = (cand_len == '0) ? BLW'(1) : cand_len;
  assign fits      = CW'(bus.room_avail) >= CW'(burst_len);
  assign accept    = |(gnt_q & bus.req_vld);
  assign last_word = accept && (cnt == BLW'(1));

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] idle_cnt, idle_nxt;

  assign to_hit = (state == BURST) && !accept && (idle_cnt == TW'(TO_CYC - 1));

  // Cycles since the last accepted word of the current burst
  always_comb begin
    idle_nxt = '0;
    if (state == BURST && !accept && !to_hit) idle_nxt = idle_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else        idle_cnt <= idle_nxt;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_q      <= '0;
      fifo_wen_q <= 1'b0;
      fifo_din_q <= '0;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
      rr_ptr     <= IW'(NREQ - 1);
      cnt        <= '0;
      drain      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_q      <= gnt_nxt;
      fifo_wen_q <= fifo_wen_nxt;
      fifo_din_q <= fifo_din_nxt;
      busy_q     <= (state_nxt != IDLE);
      cur_id_q   <= cur_id_nxt;
      rr_ptr     <= rr_ptr_nxt;
      cnt        <= cnt_nxt;
      drain      <= drain_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ARB;
      ARB: begin
        if (!any_req)  state_nxt = IDLE;
        else if (fits) state_nxt = BURST;
      end
      BURST:   if (last_word || to_hit) state_nxt = DRAIN;
      DRAIN:   if (drain) state_nxt = any_req ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Blocked head-of-line candidate is never skipped, so long bursts cannot starve
  always_comb begin
    gnt_nxt      = gnt_q;
    cur_id_nxt   = cur_id_q;
    rr_ptr_nxt   = rr_ptr;
    cnt_nxt      = cnt;
    fifo_wen_nxt = 1'b0;
    fifo_din_nxt = fifo_din_q;
    err_nxt      = 1'b0;
    drain_nxt    = 1'b0;
    case (state)
      ARB: begin
        if (any_req && fits) begin
          gnt_nxt    = NREQ'(1) << cand;
          cur_id_nxt = cand;
          rr_ptr_nxt = cand;
          cnt_nxt    = burst_len;
        end
      end
      BURST: begin
        if (accept) begin
          fifo_wen_nxt = 1'b1;
          fifo_din_nxt = cur_din;
          cnt_nxt      = cnt - BLW'(1);
          if (last_word) gnt_nxt = '0;
        end else if (to_hit) begin
          gnt_nxt = '0;
          err_nxt = 1'b1;
        end
      end
      DRAIN:   drain_nxt = !drain;
      default: ;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.fifo_wen = fifo_wen_q;
  assign bus.fifo_din = fifo_din_q;
  assign bus.busy     = busy_q;
  assign bus.cur_id   = cur_id_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table for grant/fit/round-robin
// behaviour plus hand-written sequences for gaps, reset and the watchdog.
module tb_fifo_wr_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 18;
  localparam int unsigned BLW  = 8;

  logic clk;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .BLW(BLW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BLW(BLW), .TO_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  vld;
    logic [15:0] room;
    logic [3:0]  egnt;
    logic        ewen;
    logic [2:0]  esrc;
    logic        ebusy;
    logic [2:0]  ecur;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic [3:0] req, logic [31:0] len, logic [3:0] vld,
                              logic [15:0] room, logic [3:0] egnt, logic ewen, logic [2:0] esrc,
                              logic ebusy, logic [2:0] ecur);
    vec_t v;
    v.rst = rst; v.req = req; v.len = len; v.vld = vld; v.room = room;
    v.egnt = egnt; v.ewen = ewen; v.esrc = esrc; v.ebusy = ebusy; v.ecur = ecur;
    tbl.push_back(v);
  endfunction

  function automatic logic [17:0] pat(int i, int k);
    return 18'((i << 14) | (k & 16'h3fff));
  endfunction

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task step();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    bus.req = '0; bus.req_len = '0; bus.req_vld = '0; bus.req_din = '0; bus.room_avail = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  logic [4:0]  vpat;
  logic [17:0] w;
  int          wens, errs, err_at;
  logic [3:0]  gnt_at_err;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.req_len = '0; bus.req_vld = '0; bus.req_din = '0; bus.room_avail = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt", bus.gnt, 0);
    chk("reset wen", bus.fifo_wen, 0);
    chk("reset din", bus.fifo_din, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset cur", bus.cur_id, 0);
    chk("reset err", bus.err, 0);
    rst_n = 1'b1;

    // single requester, len 4
    add(1, 4'h0, 32'h4, 4'h1, 100, 4'h0, 0, 0, 0, 0);
    add(0, 4'h1, 32'h4, 4'h1, 100, 4'h0, 0, 0, 1, 0);
    add(0, 4'h1, 32'h4, 4'h1, 100, 4'h1, 0, 0, 1, 0);
    for (int r = 0; r < 3; r++) add(0, 4'h1, 32'h4, 4'h1, 100, 4'h1, 1, 0, 1, 0);
    add(0, 4'h0, 32'h4, 4'h1, 100, 4'h0, 1, 0, 1, 0);
    add(0, 4'h0, 32'h4, 4'h1, 100, 4'h0, 0, 0, 1, 0);
    add(0, 4'h0, 32'h4, 4'h1, 100, 4'h0, 0, 0, 0, 0);

    // all four requesting, len 2: order 0,1,2,3,0 with DRAIN+ARB between grants
    add(1, 4'h0, 32'h02020202, 4'hf, 100, 4'h0, 0, 0, 0, 0);
    add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'h0, 0, 0, 1, 0);
    for (int g = 0; g < 4; g++) begin
      add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'(1 << g), 0, 0,     1, 3'(g));
      add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'(1 << g), 1, 3'(g), 1, 3'(g));
      add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'h0,       1, 3'(g), 1, 3'(g));
      add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'h0,       0, 0,     1, 3'(g));
      add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'h0,       0, 0,     1, 3'(g));
    end
    add(0, 4'hf, 32'h02020202, 4'hf, 100, 4'h1, 0, 0, 1, 0);
    add(0, 4'h0, 32'h02020202, 4'hf, 100, 4'h1, 1, 0, 1, 0);
    add(0, 4'h0, 32'h02020202, 4'hf, 100, 4'h0, 1, 0, 1, 0);
    add(0, 4'h0, 32'h02020202, 4'hf, 100, 4'h0, 0, 0, 1, 0);
    add(0, 4'h0, 32'h02020202, 4'hf, 100, 4'h0, 0, 0, 0, 0);

    // fit check: req0 len5 blocks on room 3, req1 is not skipped ahead
    add(1, 4'h0, 32'h105, 4'h0, 3, 4'h0, 0, 0, 0, 0);
    add(0, 4'h3, 32'h105, 4'h0, 3, 4'h0, 0, 0, 1, 0);
    add(0, 4'h3, 32'h105, 4'h0, 3, 4'h0, 0, 0, 1, 0);
    add(0, 4'h3, 32'h105, 4'h0, 3, 4'h0, 0, 0, 1, 0);
    add(0, 4'h3, 32'h105, 4'h0, 5, 4'h1, 0, 0, 1, 0);
    for (int r = 0; r < 4; r++) add(0, 4'h3, 32'h105, 4'h1, 5, 4'h1, 1, 0, 1, 0);
    add(0, 4'h0, 32'h105, 4'h1, 5, 4'h0, 1, 0, 1, 0);
    add(0, 4'h0, 32'h105, 4'h1, 5, 4'h0, 0, 0, 1, 0);
    add(0, 4'h0, 32'h105, 4'h1, 5, 4'h0, 0, 0, 0, 0);
    // len 0 counts as one word; ungranted vld ignored
    add(0, 4'h4, 32'h0, 4'hf, 5, 4'h0, 0, 0, 1, 0);
    add(0, 4'h4, 32'h0, 4'hf, 5, 4'h4, 0, 0, 1, 2);
    add(0, 4'h0, 32'h0, 4'hf, 5, 4'h0, 1, 2, 1, 2);
    add(0, 4'h0, 32'h0, 4'hf, 5, 4'h0, 0, 0, 1, 2);
    add(0, 4'h0, 32'h0, 4'hf, 5, 4'h0, 0, 0, 0, 2);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      bus.req        = tbl[k].req;
      bus.req_len    = tbl[k].len;
      bus.req_vld    = tbl[k].vld;
      bus.room_avail = tbl[k].room;
      for (int i = 0; i < 4; i++) bus.req_din[i*DW +: DW] = pat(i, k);
      step();
      chk($sformatf("v%0d gnt", k),  bus.gnt,      tbl[k].egnt);
      chk($sformatf("v%0d wen", k),  bus.fifo_wen, tbl[k].ewen);
      chk($sformatf("v%0d busy", k), bus.busy,     tbl[k].ebusy);
      chk($sformatf("v%0d cur", k),  bus.cur_id,   tbl[k].ecur);
      chk($sformatf("v%0d err", k),  bus.err,      0);
      if (tbl[k].ewen) chk($sformatf("v%0d din", k), bus.fifo_din, pat(int'(tbl[k].esrc), k));
    end

    // gaps in req_vld and early req deassert during a len 3 burst
    do_reset();
    bus.req = 4'h1; bus.req_len = 32'h3; bus.room_avail = 100;
    step();
    step();
    chk("t4 grant", bus.gnt, 4'h1);
    bus.req = 4'h0;
    vpat = 5'b11001;
    wens = 0;
    for (int j = 0; j < 5; j++) begin
      bus.req_vld = {3'b000, vpat[j]};
      w = 18'h3a0 + 18'(j);
      bus.req_din[17:0] = w;
      step();
      chk($sformatf("t4 gnt %0d", j), bus.gnt, (j < 4) ? 4'h1 : 4'h0);
      chk($sformatf("t4 wen %0d", j), bus.fifo_wen, vpat[j]);
      if (bus.fifo_wen) begin
        wens++;
        chk($sformatf("t4 din %0d", j), bus.fifo_din, w);
      end
    end
    bus.req_vld = 4'h1;
    for (int j = 0; j < 3; j++) begin
      step();
      if (bus.fifo_wen) wens++;
    end
    chk("t4 words", wens, 3);
    chk("t4 idle busy", bus.busy, 0);

    // reset in cycle 2 of a len 8 burst on requester 2
    do_reset();
    bus.req = 4'h4; bus.req_len = 32'h00080000; bus.req_vld = 4'h4; bus.room_avail = 100;
    bus.req_din[2*DW +: DW] = 18'h2beef;
    step();
    step();
    chk("t5 grant", bus.gnt, 4'h4);
    chk("t5 cur", bus.cur_id, 2);
    step();
    chk("t5 wen", bus.fifo_wen, 1);
    chk("t5 din", bus.fifo_din, 18'h2beef);
    rst_n = 1'b0;
    #1;
    chk("t5 rst gnt", bus.gnt, 0);
    chk("t5 rst wen", bus.fifo_wen, 0);
    chk("t5 rst din", bus.fifo_din, 0);
    chk("t5 rst busy", bus.busy, 0);
    chk("t5 rst cur", bus.cur_id, 0);
    chk("t5 rst err", bus.err, 0);
    bus.req = 4'hf; bus.req_len = 32'h01010101; bus.req_vld = 4'h0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t5 rr gnt", bus.gnt, 4'h1);
    chk("t5 rr cur", bus.cur_id, 0);

    // stalled burst: one word then no more valid data
    do_reset();
    bus.req = 4'h1; bus.req_len = 32'h4; bus.room_avail = 100;
    step();
    step();
    chk("t6 grant", bus.gnt, 4'h1);
    bus.req = 4'h0;
    bus.req_vld = 4'h1;
    step();
    chk("t6 first wen", bus.fifo_wen, 1);
    bus.req_vld = 4'h0;
    wens = 0; errs = 0; err_at = 0; gnt_at_err = 4'hf;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.fifo_wen) wens++;
      if (bus.err) begin
        errs++;
        if (err_at == 0) begin
          err_at = n;
          gnt_at_err = bus.gnt;
        end
      end
    end
    chk("t6 extra words", wens, 0);
`ifdef FIFO_ARB_TIMEOUT_EN
    chk("t6 err cycle", err_at, 16);
    chk("t6 err pulses", errs, 1);
    chk("t6 gnt at err", gnt_at_err, 0);
    chk("t6 busy after", bus.busy, 0);
`else
    chk("t6 err pulses", errs, 0);
    chk("t6 gnt held", bus.gnt, 4'h1);
    chk("t6 busy held", bus.busy, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
